// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the RAM/IO memory arbiter.
// Word addresses drop the two byte-offset bits of a 32-bit byte address.
package mem_arb_pkg;

   localparam int IO_BIT_DEFAULT = 22;
   localparam int WORD_ADDR_W    = 30;

   typedef enum logic [0:0] {
      IO_IDLE = 1'b0,
      IO_BUSY = 1'b1
   } io_state_e;

   typedef enum logic [0:0] {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
      return byte_addr[31:2];
   endfunction

endpackage

// File: rtl/mem_arb_io_fsm.sv
// IO-page access sequencer: captures one data access, holds it on io_* until
// io_ready, then returns load data one cycle later.
module mem_arb_io_fsm
   import mem_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   start_we,
   input  logic [WORD_ADDR_W-1:0] start_addr,
   input  logic [31:0]            start_wdata,
   input  logic                   io_ready,
   input  logic [31:0]            io_rdata,
   output logic                   busy,
   output logic                   io_req,
   output logic                   io_we,
   output logic [WORD_ADDR_W-1:0] io_addr,
   output logic [31:0]            io_wdata,
   output logic                   rsp_valid,
   output logic [31:0]            rsp_data
);

   io_state_e              state_r;
   logic                   we_r;
   logic [WORD_ADDR_W-1:0] addr_r;
   logic [31:0]            wdata_r;
   logic                   rsp_valid_r;
   logic [31:0]            rsp_data_r;
   logic                   done_s;

   assign done_s = (state_r == IO_BUSY) && io_ready;

   // IDLE/BUSY sequencing; io_ready outside BUSY is ignored
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IO_IDLE;
      end else begin
         case (state_r)
            IO_IDLE: state_r <= start    ? IO_BUSY : IO_IDLE;
            IO_BUSY: state_r <= io_ready ? IO_IDLE : IO_BUSY;
            default: state_r <= IO_IDLE;
         endcase
      end
   end

   // Capture the granted access; held stable for the whole BUSY period
   always_ff @(posedge clk) begin
      if (reset) begin
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= 32'h0;
      end else if (start && (state_r == IO_IDLE)) begin
         we_r    <= start_we;
         addr_r  <= start_addr;
         wdata_r <= start_wdata;
      end else begin
         we_r    <= we_r;
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
      end
   end

   // Load completion pulse, one cycle after io_ready; stores finish silently
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= 32'h0;
      end else begin
         rsp_valid_r <= done_s && !we_r;
         if (done_s && !we_r) begin
            rsp_data_r <= io_rdata;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end
   end

   assign busy      = (state_r == IO_BUSY);
   assign io_req    = (state_r == IO_BUSY);
   assign io_we     = we_r;
   assign io_addr   = addr_r;
   assign io_wdata  = wdata_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between fetch and load/store, with data
// accesses to the IO page diverted to a variable-latency IO port.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int IO_BIT     = IO_BIT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   if_req,
   input  logic [31:0]            if_addr,
   output logic                   if_gnt,
   output logic                   if_rvalid,
   output logic [31:0]            if_rdata,
   input  logic                   d_req,
   input  logic                   d_we,
   input  logic [3:0]             d_be,
   input  logic [31:0]            d_addr,
   input  logic [31:0]            d_wdata,
   output logic                   d_gnt,
   output logic                   d_rvalid,
   output logic [31:0]            d_rdata,
   output logic                   ram_en,
   output logic [3:0]             ram_we,
   output logic [WORD_ADDR_W-1:0] ram_addr,
   output logic [31:0]            ram_wdata,
   input  logic [31:0]            ram_rdata,
   output logic                   io_req,
   output logic                   io_we,
   output logic [WORD_ADDR_W-1:0] io_addr,
   output logic [31:0]            io_wdata,
   input  logic                   io_ready,
   input  logic [31:0]            io_rdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt_r;
   logic             starve_hit_s;
   logic             d_io_s;
   logic             d_ram_gnt_s;
   logic             d_io_gnt_s;
   logic             if_gnt_s;
   logic             io_busy_s;
   logic             io_rsp_valid_s;
   logic [31:0]      io_rsp_data_s;
   logic             rd_pend_r;
   owner_e           owner_r;
   logic             if_rvalid_s;
   logic             d_ram_rvalid_s;
   logic [31:0]      if_hold_r;
   logic [31:0]      d_hold_r;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

   // Grant decision; data wins the RAM unless fetch has been starved too long
   always_comb begin
      d_io_s       = d_addr[IO_BIT];
      starve_hit_s = (starve_cnt_r == CNT_W'(STARVE_MAX));
      d_ram_gnt_s  = 1'b0;
      d_io_gnt_s   = 1'b0;
      if_gnt_s     = 1'b0;
      if (reset) begin
         d_ram_gnt_s = 1'b0;
         d_io_gnt_s  = 1'b0;
         if_gnt_s    = 1'b0;
      end else begin
         d_ram_gnt_s = d_req && !io_busy_s && !d_io_s && !(if_req && starve_hit_s);
         d_io_gnt_s  = d_req && !io_busy_s && d_io_s;
         if_gnt_s    = if_req && !d_ram_gnt_s;
      end
   end

   // RAM port mux driven from whichever port holds the grant
   always_comb begin
      ram_en = if_gnt_s | d_ram_gnt_s;
      if (d_ram_gnt_s) begin
         ram_addr  = word_addr(d_addr);
         ram_wdata = d_wdata;
         ram_we    = d_we ? d_be : 4'b0000;
      end else begin
         ram_addr  = word_addr(if_addr);
         ram_wdata = 32'h0;
         ram_we    = 4'b0000;
      end
   end

   // Counts consecutive denied fetch cycles, saturating at STARVE_MAX
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= '0;
      end else if (if_req && !if_gnt_s) begin
         if (!starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= '0;
      end
   end

   // Owner of the in-flight RAM read; stores leave nothing pending
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend_r <= 1'b0;
         owner_r   <= OWN_IF;
      end else begin
         rd_pend_r <= if_gnt_s | (d_ram_gnt_s & ~d_we);
         owner_r   <= d_ram_gnt_s ? OWN_D : OWN_IF;
      end
   end

   assign if_rvalid_s    = rd_pend_r && (owner_r == OWN_IF);
   assign d_ram_rvalid_s = rd_pend_r && (owner_r == OWN_D);

   // Last returned words, presented on *_rdata between valid pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         if_hold_r <= 32'h0;
         d_hold_r  <= 32'h0;
      end else begin
         if (if_rvalid_s) begin
            if_hold_r <= ram_rdata;
         end else begin
            if_hold_r <= if_hold_r;
         end
         if (d_ram_rvalid_s) begin
            d_hold_r <= ram_rdata;
         end else if (io_rsp_valid_s) begin
            d_hold_r <= io_rsp_data_s;
         end else begin
            d_hold_r <= d_hold_r;
         end
      end
   end

   mem_arb_io_fsm u_io_fsm (
      .clk         (clk),
      .reset       (reset),
      .start       (d_io_gnt_s),
      .start_we    (d_we),
      .start_addr  (word_addr(d_addr)),
      .start_wdata (d_wdata),
      .io_ready    (io_ready),
      .io_rdata    (io_rdata),
      .busy        (io_busy_s),
      .io_req      (io_req),
      .io_we       (io_we),
      .io_addr     (io_addr),
      .io_wdata    (io_wdata),
      .rsp_valid   (io_rsp_valid_s),
      .rsp_data    (io_rsp_data_s)
   );

   // A RAM data read and an IO load response can never land in the same cycle
   assign if_gnt    = if_gnt_s;
   assign d_gnt     = d_ram_gnt_s | d_io_gnt_s;
   assign if_rvalid = if_rvalid_s;
   assign if_rdata  = if_rvalid_s ? ram_rdata : if_hold_r;
   assign d_rvalid  = d_ram_rvalid_s | io_rsp_valid_s;
   assign d_rdata   = d_ram_rvalid_s ? ram_rdata :
                      (io_rsp_valid_s ? io_rsp_data_s : d_hold_r);

endmodule
